vram_port: RTL

VRAM_PORT -- requirements
Module: vram_port

---
 rtl/vram_port.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vram_port.sv
// CPU/video arbitration front-end for a single-port character VRAM with write FIFO and read prefetch.
// Optional: define VRAM_AUTOINC_EN to post-increment ADDR on every DATA access.
module vram_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SEL,
  input  logic [1:0]            A,
  input  logic                  R_W_n,
  input  logic [7:0]            DI,
  output logic [7:0]            DO,
  input  logic                  VID_REQ,
  input  logic [ADDR_WIDTH-1:0] VID_A,
  output logic [7:0]            VID_Q,
  output logic                  VID_VALID,
  output logic [ADDR_WIDTH-1:0] RAM_A,
  output logic [7:0]            RAM_D,
  output logic                  RAM_WE,
  input  logic [7:0]            RAM_Q
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int HI_W  = ADDR_WIDTH - 8;
  localparam int ENT_W = ADDR_WIDTH + 8;

  typedef enum logic [1:0] {IDLE, VID, CPU_RD, CPU_WR} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] pf_addr_reg;
  logic [7:0]            rdbuf_reg;
  logic                  rd_pend_reg, pf_issued_reg, overrun_reg;
  logic                  rd_vid_reg, rd_cpu_reg;
  logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]        count_reg;

  logic cpu_rd, cpu_wr, data_rd, data_wr, hi_wr, lo_wr, status_rd;
  logic fifo_empty, fifo_full, pop, push, pf_req, issue_rd;
  logic [ENT_W-1:0] head;
  logic [7:0]       status;

  assign cpu_rd    = SEL & R_W_n;
  assign cpu_wr    = SEL & ~R_W_n;
  assign lo_wr     = cpu_wr && (A == 2'd0);
  assign hi_wr     = cpu_wr && (A == 2'd1);
  assign data_wr   = cpu_wr && (A == 2'd2);
  assign data_rd   = cpu_rd && (A == 2'd2);
  assign status_rd = cpu_rd && (A == 2'd3);

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr_reg];

  // Video always wins; a prefetch only goes once every older write has reached RAM.
  assign pop      = !VID_REQ && !fifo_empty;
  assign push     = data_wr && (!fifo_full || pop);
  assign pf_req   = data_rd || hi_wr;
  assign issue_rd = !VID_REQ && fifo_empty && rd_pend_reg && !pf_issued_reg && !pf_req;

  assign status = {4'b0, overrun_reg, rd_pend_reg, fifo_empty, fifo_full};

  always_comb begin
    addr_next = addr_reg;
    if (lo_wr) begin
      addr_next = {addr_reg[ADDR_WIDTH-1:8], DI};
    end else if (hi_wr) begin
      addr_next = {DI[HI_W-1:0], addr_reg[7:0]};
    end
`ifdef VRAM_AUTOINC_EN
    else if (data_wr || data_rd) begin
      addr_next = addr_reg + ADDR_WIDTH'(1);
    end
`endif
  end

  always_comb begin
    DO = 8'h00;
    if (cpu_rd) begin
      case (A)
        2'd0:    DO = addr_reg[7:0];
        2'd1:    DO = 8'(addr_reg[ADDR_WIDTH-1:8]);
        2'd2:    DO = rdbuf_reg;
        default: DO = status;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_reg] <= {addr_reg, DI};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      pf_addr_reg   <= '0;
      rdbuf_reg     <= 8'h00;
      rd_pend_reg   <= 1'b0;
      pf_issued_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      rd_vid_reg    <= 1'b0;
      rd_cpu_reg    <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      RAM_A         <= '0;
      RAM_D         <= 8'h00;
      RAM_WE        <= 1'b0;
      VID_Q         <= 8'h00;
      VID_VALID     <= 1'b0;
    end else begin
      addr_reg <= addr_next;

      if (status_rd)            overrun_reg <= 1'b0;
      else if (data_wr && !push) overrun_reg <= 1'b1;

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

      RAM_WE <= 1'b0;
      if (VID_REQ) begin
        state_reg <= VID;
        RAM_A     <= VID_A;
      end else if (issue_rd) begin
        state_reg     <= CPU_RD;
        RAM_A         <= pf_addr_reg;
        pf_issued_reg <= 1'b1;
      end else if (pop) begin
        state_reg <= CPU_WR;
        RAM_A     <= head[ENT_W-1:8];
        RAM_D     <= head[7:0];
        RAM_WE    <= 1'b1;
      end else begin
        state_reg <= IDLE;
      end

      // RAM_Q arrives the cycle after the address; a newer prefetch request kills older reads.
      rd_vid_reg <= (state_reg == VID);
      rd_cpu_reg <= (state_reg == CPU_RD) && !pf_req;

      VID_VALID <= rd_vid_reg;
      if (rd_vid_reg) VID_Q <= RAM_Q;

      if (rd_cpu_reg && !pf_req) begin
        rdbuf_reg     <= RAM_Q;
        rd_pend_reg   <= 1'b0;
        pf_issued_reg <= 1'b0;
      end
      if (pf_req) begin
        pf_addr_reg   <= addr_next;
        rd_pend_reg   <= 1'b1;
        pf_issued_reg <= 1'b0;
      end
    end
  end

endmodule
